// File: rtl/video_ts_pkg.sv
// Shared definitions for the TS renderer: graphics address layout, nibble order,
// transparent index and the renderer state enum.
package video_ts_pkg;

  localparam int PAGE_MSB = 20;
  localparam int PAGE_LSB = 13;
  localparam int LINE_MSB = 12;
  localparam int LINE_LSB = 7;
  localparam int WORD_MSB = 6;
  localparam int WORD_LSB = 0;

  localparam logic [3:0] TRANSPARENT_PIX = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } tsr_state_e;

  // Pixel order inside a 4bpp graphics word: low byte first, high nibble first.
  function automatic logic [3:0] pixNibble(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = word[7:4];
      2'd1:    nib = word[3:0];
      2'd2:    nib = word[15:12];
      default: nib = word[11:8];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/video_ts_render_if.sv
// Bundle of the TS engine task port, DRAM graphics slot and line-buffer write port.
interface video_ts_render_if;

  logic        start;
  logic        tsr_go;
  logic [5:0]  tsr_addr;
  logic [8:0]  tsr_line;
  logic [7:0]  tsr_page;
  logic [8:0]  tsr_x;
  logic [2:0]  tsr_xs;
  logic        tsr_xf;
  logic [3:0]  tsr_pal;
  logic        tsr_rdy;
  logic [20:0] dram_addr;
  logic        dram_req;
  logic        dram_next;
  logic [15:0] dram_rdata;
  logic [8:0]  ts_waddr;
  logic [7:0]  ts_wdata;
  logic        ts_we;

  modport master (
    output start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    output dram_next, dram_rdata,
    input  tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );

  modport slave (
    input  start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    input  dram_next, dram_rdata,
    output tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );

endinterface

// File: rtl/video_ts_pixser.sv
// Word register and 4-pixel serializer; emits one nibble per clock from the held word.
module video_ts_pixser
  import video_ts_pkg::*;
(
  input  logic        clk,
  input  logic        res_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [15:0] word_i,
  output logic [3:0]  pix_o,
  output logic        pix_valid_o,
  output logic        last_pix_o,
  output logic        empty_o
);

  logic [15:0] word_q, word_d;
  logic        full_q, full_d;
  logic [1:0]  cnt_q, cnt_d;

  // A load is only ever requested when empty or on the final nibble, so it never overwrites pending pixels.
  always_comb begin
    word_d = word_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      full_d = 1'b0;
      cnt_d  = '0;
    end else if (load_i) begin
      word_d = word_i;
      full_d = 1'b1;
      cnt_d  = '0;
    end else if (full_q) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      word_q <= '0;
      full_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pix_o       = pixNibble(word_q, cnt_q);
  assign pix_valid_o = full_q;
  assign last_pix_o  = full_q && (cnt_q == 2'd3);
  assign empty_o     = !full_q;

endmodule

// File: rtl/video_ts_render.sv
// TS renderer: latches one tile/sprite task, fetches its graphics words and writes
// non-transparent palette-tagged pixels into the line buffer, optionally X-flipped.
module video_ts_render
  import video_ts_pkg::*;
(
  input  logic             clk,
  input  logic             res_n,
  video_ts_render_if.slave bus
);

  tsr_state_e  state_q;
  logic        rdy_q;
  logic [7:0]  page_q;
  logic [8:0]  line_q;
  logic [5:0]  addr_q;
  logic [2:0]  xs_q;
  logic        xf_q;
  logic [3:0]  pal_q;
  logic [3:0]  wCnt_q;
  logic [8:0]  waddr_q;

  logic [3:0]  pix;
  logic        pixValid;
  logic        lastPix;
  logic        wordEmpty;
  logic        accept;
  logic        load;
  logic        lastWord;
  logic [20:0] dramAddr;

  assign accept   = bus.tsr_go && rdy_q && !bus.start;
  assign load     = bus.dram_next && (state_q == FETCH);
  assign lastWord = (wCnt_q == {xs_q, 1'b1});

  video_ts_pixser u_pixser (
    .clk         (clk),
    .res_n       (res_n),
    .clear_i     (bus.start),
    .load_i      (load),
    .word_i      (bus.dram_rdata),
    .pix_o       (pix),
    .pix_valid_o (pixValid),
    .last_pix_o  (lastPix),
    .empty_o     (wordEmpty)
  );

  // Page and bitmap-line high bits share the top field; the word index wraps within the line.
  always_comb begin
    dramAddr = '0;
    dramAddr[PAGE_MSB:PAGE_LSB] = page_q + {5'b0, line_q[8:6]};
    dramAddr[LINE_MSB:LINE_LSB] = line_q[5:0];
    dramAddr[WORD_MSB:WORD_LSB] = {addr_q, 1'b0} + {3'b0, wCnt_q};
  end

  always_ff @(posedge clk) begin
    if (!res_n || bus.start) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      page_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      xs_q    <= '0;
      xf_q    <= 1'b0;
      pal_q   <= '0;
      wCnt_q  <= '0;
      waddr_q <= '0;
    end else begin
      if (pixValid) waddr_q <= xf_q ? waddr_q - 9'd1 : waddr_q + 9'd1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            page_q  <= bus.tsr_page;
            line_q  <= bus.tsr_line;
            addr_q  <= bus.tsr_addr;
            xs_q    <= bus.tsr_xs;
            xf_q    <= bus.tsr_xf;
            pal_q   <= bus.tsr_pal;
            wCnt_q  <= '0;
            // Flipped segments start at the far end and walk backwards.
            waddr_q <= bus.tsr_x + (bus.tsr_xf ? {3'b000, bus.tsr_xs, 3'b111} : 9'd0);
            rdy_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (bus.dram_next) begin
            wCnt_q <= wCnt_q + 4'd1;
            if (lastWord) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (lastPix) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tsr_rdy   = rdy_q;
  assign bus.dram_addr = dramAddr;
  assign bus.dram_req  = (state_q == FETCH) && (wordEmpty || lastPix);
  assign bus.ts_we     = pixValid && (pix != TRANSPARENT_PIX);
  assign bus.ts_wdata  = {pal_q, pix};
  assign bus.ts_waddr  = waddr_q;

endmodule

// File: tb/tb_video_ts_render.sv
// Bench for video_ts_render: directed task table, randomized tasks against a
// pixel-level model, and abort/reset corner sequences.
module tb_video_ts_render;

  logic clk;
  logic res_n;

  video_ts_render_if bus ();

  video_ts_render dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [7:0] data;
  } wrT;

  typedef struct {
    logic [7:0]  pg;
    logic [8:0]  ln;
    logic [5:0]  ad;
    logic [8:0]  x;
    logic [2:0]  xs;
    logic        xf;
    logic [3:0]  pal;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nWr;
    logic [8:0]  fA;
    logic [7:0]  fD;
    logic [8:0]  lA;
    logic [7:0]  lD;
    logic [20:0] dAddr;
    int          rdy;
  } vecT;

  int          compared = 0;
  int          failed = 0;
  logic [15:0] curWords [16];
  int          deliverCyc [16];
  wrT          capQ [$];
  wrT          expQ [$];
  int          rdyCyc;
  bit          timedOut;
  logic [20:0] firstDram;
  vecT         vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Graphics word address computed straight from the memory map with plain arithmetic.
  function automatic int expDram(input int pg, input int ln, input int ad, input int i);
    return ((pg + ln / 64) % 256) * 8192 + (ln % 64) * 128 + ((ad * 2 + i) % 128);
  endfunction

  task automatic buildModel(input int x, input int xs, input int xf, input int pal);
    int w;
    int sh;
    int nib;
    w = (xs + 1) * 8;
    expQ.delete();
    for (int p = 0; p < w; p++) begin
      case (p % 4)
        0:       sh = 4;
        1:       sh = 0;
        2:       sh = 12;
        default: sh = 8;
      endcase
      nib = (int'(curWords[p / 4]) >> sh) & 15;
      if (nib != 0)
        expQ.push_back('{deliverCyc[p / 4] + 1 + (p % 4),
                         9'((x + (xf != 0 ? w - 1 - p : p)) % 512),
                         8'(pal * 16 + nib)});
    end
  endtask

  task automatic applyStimulus(input int pg, input int ln, input int ad, input int x,
                               input int xs, input int xf, input int pal,
                               input int gapMax, input bit noise);
    int  n;
    int  wi;
    int  gap;
    int  c;
    int  pixLeft;
    bit  reqBad;
    bit  delivered;
    n = (xs + 1) * 2;
    wi = 0;
    pixLeft = 0;
    reqBad = 0;
    capQ.delete();
    firstDram = '0;
    bus.tsr_page = pg[7:0];
    bus.tsr_line = ln[8:0];
    bus.tsr_addr = ad[5:0];
    bus.tsr_x    = x[8:0];
    bus.tsr_xs   = xs[2:0];
    bus.tsr_xf   = xf[0];
    bus.tsr_pal  = pal[3:0];
    bus.tsr_go   = 1'b1;
    step();
    bus.tsr_go = 1'b0;
    c = 1;
    gap = $urandom_range(gapMax, 0);
    timedOut = 1'b1;
    rdyCyc = -1;
    while (c < 400) begin
      delivered = 1'b0;
      if (bus.ts_we) capQ.push_back('{c, bus.ts_waddr, bus.ts_wdata});
      if (pixLeft >= 2 && bus.dram_req) reqBad = 1'b1;
      if (bus.tsr_rdy) begin
        timedOut = 1'b0;
        rdyCyc = c;
        break;
      end
      if (bus.dram_req && wi < n) begin
        if (gap == 0) begin
          checkOutput("dramAddr", 32'(bus.dram_addr), expDram(pg, ln, ad, wi));
          if (wi == 0) firstDram = bus.dram_addr;
          bus.dram_next  = 1'b1;
          bus.dram_rdata = curWords[wi];
          deliverCyc[wi] = c;
          wi++;
          delivered = 1'b1;
          gap = $urandom_range(gapMax, 0);
        end else begin
          gap--;
        end
      end
      if (noise && $urandom_range(3, 0) == 0) begin
        bus.tsr_go   = 1'b1;
        bus.tsr_page = 8'($urandom);
        bus.tsr_x    = 9'($urandom);
        bus.tsr_xs   = 3'($urandom);
        bus.tsr_pal  = 4'($urandom);
      end
      pixLeft = delivered ? 4 : (pixLeft > 0 ? pixLeft - 1 : 0);
      step();
      bus.dram_next = 1'b0;
      bus.tsr_go    = 1'b0;
      c++;
    end
    checkOutput("timeout", 32'(timedOut), 32'd0);
    checkOutput("wordsFetched", wi, n);
    checkOutput("reqWhileFull", 32'(reqBad), 32'd0);
    if (!timedOut && wi == n) begin
      checkOutput("rdyCycle", rdyCyc, deliverCyc[n - 1] + 5);
      buildModel(x, xs, xf, pal);
      checkOutput("nWrites", capQ.size(), expQ.size());
      for (int i = 0; i < capQ.size() && i < expQ.size(); i++) begin
        checkOutput("wrCycle", capQ[i].cyc, expQ[i].cyc);
        checkOutput("wrAddr", 32'(capQ[i].addr), 32'(expQ[i].addr));
        checkOutput("wrData", 32'(capQ[i].data), 32'(expQ[i].data));
      end
    end
  endtask

  initial begin
    int weCount;
    vecs[0] = '{8'h10, 9'h041, 6'd3, 9'd100, 3'd0, 1'b0, 4'd5, 16'h2143, 16'h6587,
                8, 9'd100, 8'h54, 9'd107, 8'h55, 21'h22086, 10};
    vecs[1] = '{8'h10, 9'h041, 6'd3, 9'd100, 3'd0, 1'b1, 4'd5, 16'h2143, 16'h6587,
                8, 9'd107, 8'h54, 9'd100, 8'h55, 21'h22086, 10};
    vecs[2] = '{8'h10, 9'h041, 6'd3, 9'd100, 3'd0, 1'b0, 4'd5, 16'h0F00, 16'h0000,
                1, 9'd103, 8'h5F, 9'd103, 8'h5F, 21'h22086, 10};
    vecs[3] = '{8'h10, 9'h041, 6'd3, 9'd508, 3'd0, 1'b0, 4'd3, 16'h1111, 16'h1111,
                8, 9'd508, 8'h31, 9'd3, 8'h31, 21'h22086, 10};
    vecs[4] = '{8'hFF, 9'h040, 6'd63, 9'd0, 3'd1, 1'b0, 4'd1, 16'h1234, 16'h5678,
                16, 9'd0, 8'h13, 9'd15, 8'h16, 21'h0007E, 18};

    res_n          = 1'b0;
    bus.start      = 1'b0;
    bus.tsr_go     = 1'b0;
    bus.tsr_addr   = '0;
    bus.tsr_line   = '0;
    bus.tsr_page   = '0;
    bus.tsr_x      = '0;
    bus.tsr_xs     = '0;
    bus.tsr_xf     = 1'b0;
    bus.tsr_pal    = '0;
    bus.dram_next  = 1'b0;
    bus.dram_rdata = '0;
    repeat (3) step();
    checkOutput("rstRdy", 32'(bus.tsr_rdy), 32'd1);
    checkOutput("rstReq", 32'(bus.dram_req), 32'd0);
    checkOutput("rstWe", 32'(bus.ts_we), 32'd0);
    checkOutput("rstWaddr", 32'(bus.ts_waddr), 32'd0);
    checkOutput("rstWdata", 32'(bus.ts_wdata), 32'd0);
    checkOutput("rstDramAddr", 32'(bus.dram_addr), 32'd0);
    res_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 16; j++) curWords[j] = (j % 2 == 0) ? vecs[i].w0 : vecs[i].w1;
      applyStimulus(vecs[i].pg, vecs[i].ln, vecs[i].ad, vecs[i].x, vecs[i].xs,
                    vecs[i].xf, vecs[i].pal, 0, 1'b0);
      checkOutput("tblNWr", capQ.size(), vecs[i].nWr);
      checkOutput("tblDram0", 32'(firstDram), 32'(vecs[i].dAddr));
      checkOutput("tblRdy", rdyCyc, vecs[i].rdy);
      if (capQ.size() > 0) begin
        checkOutput("tblFirstAddr", 32'(capQ[0].addr), 32'(vecs[i].fA));
        checkOutput("tblFirstData", 32'(capQ[0].data), 32'(vecs[i].fD));
        checkOutput("tblLastAddr", 32'(capQ[capQ.size() - 1].addr), 32'(vecs[i].lA));
        checkOutput("tblLastData", 32'(capQ[capQ.size() - 1].data), 32'(vecs[i].lD));
      end
    end

    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < 16; j++) begin
        curWords[j] = 16'($urandom);
        for (int k = 0; k < 4; k++)
          if ($urandom_range(3, 0) == 0) curWords[j] = curWords[j] & ~(16'hF << (4 * k));
      end
      applyStimulus($urandom_range(255, 0), $urandom_range(511, 0), $urandom_range(63, 0),
                    $urandom_range(511, 0), (t == 0) ? 7 : $urandom_range(7, 0),
                    $urandom_range(1, 0), $urandom_range(15, 0),
                    (t == 0) ? 3 : $urandom_range(3, 0), 1'b1);
    end

    // Abort in FETCH with go and a word arriving in the same cycle.
    bus.tsr_page = 8'h22; bus.tsr_line = 9'h011; bus.tsr_addr = 6'd5;
    bus.tsr_x = 9'd40; bus.tsr_xs = 3'd3; bus.tsr_xf = 1'b0; bus.tsr_pal = 4'd9;
    bus.tsr_go = 1'b1;
    step();
    bus.tsr_go = 1'b0;
    checkOutput("goRdyC1", 32'(bus.tsr_rdy), 32'd0);
    checkOutput("goReqC1", 32'(bus.dram_req), 32'd1);
    bus.start = 1'b1; bus.tsr_go = 1'b1; bus.dram_next = 1'b1; bus.dram_rdata = 16'hFFFF;
    step();
    bus.start = 1'b0; bus.tsr_go = 1'b0; bus.dram_next = 1'b0;
    checkOutput("abortRdy", 32'(bus.tsr_rdy), 32'd1);
    checkOutput("abortReq", 32'(bus.dram_req), 32'd0);
    checkOutput("abortWe", 32'(bus.ts_we), 32'd0);
    weCount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.ts_we || bus.dram_req) weCount++;
    end
    checkOutput("abortQuiet", weCount, 0);
    checkOutput("abortRdyHold", 32'(bus.tsr_rdy), 32'd1);

    // Reset while the last word is being serialized.
    bus.tsr_xs = 3'd0; bus.tsr_go = 1'b1;
    step();
    bus.tsr_go = 1'b0;
    checkOutput("drainReqW0", 32'(bus.dram_req), 32'd1);
    bus.dram_next = 1'b1; bus.dram_rdata = 16'h1111;
    step();
    bus.dram_next = 1'b0;
    repeat (3) step();
    checkOutput("drainReqW1", 32'(bus.dram_req), 32'd1);
    bus.dram_next = 1'b1; bus.dram_rdata = 16'h2222;
    step();
    bus.dram_next = 1'b0;
    checkOutput("drainWe", 32'(bus.ts_we), 32'd1);
    step();
    res_n = 1'b0;
    step();
    res_n = 1'b1;
    checkOutput("rstDrainRdy", 32'(bus.tsr_rdy), 32'd1);
    checkOutput("rstDrainReq", 32'(bus.dram_req), 32'd0);
    checkOutput("rstDrainWe", 32'(bus.ts_we), 32'd0);
    checkOutput("rstDrainWdata", 32'(bus.ts_wdata), 32'd0);
    checkOutput("rstDrainWaddr", 32'(bus.ts_waddr), 32'd0);
    step();
    checkOutput("rstDrainWe2", 32'(bus.ts_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
